// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory handshake signals around the arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it
// (fetch stage, load/store stage and memory model together).
interface mem_arbiter_if;
   // Fetch requester
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_ready;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;

   // Data requester
   logic        i_dm_req;
   logic [31:0] i_dm_addr;
   logic        i_dm_wen;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_mask;
   logic        o_dm_ready;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;

   // Unified memory port
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        o_mem_wen;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_mask;
   logic        i_mem_ready;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   // Status
   logic        o_busy;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_ready, o_if_rvalid, o_if_rdata,
      input  i_dm_req, i_dm_addr, i_dm_wen, i_dm_wdata, i_dm_mask,
      output o_dm_ready, o_dm_rvalid, o_dm_rdata,
      output o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
      input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
      output o_busy
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_ready, o_if_rvalid, o_if_rdata,
      output i_dm_req, i_dm_addr, i_dm_wen, i_dm_wdata, i_dm_mask,
      input  o_dm_ready, o_dm_rvalid, o_dm_rdata,
      input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
      output i_mem_ready, i_mem_rvalid, i_mem_rdata,
      input  o_busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding round-robin arbiter sharing one variable-latency memory
// port between instruction fetch and load/store. One transaction is in
// flight at a time; its response is steered back to whichever side owns it.
module mem_arbiter (
   input  logic         i_clk,
   input  logic         i_rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_t;

   state_t      state_q, state_d;
   grant_t      grant_q, grant_d;
   grant_t      last_grant_q, last_grant_d;
   logic [31:0] addr_q, addr_d;
   logic        wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] rdata_q, rdata_d;

   logic        pick_dm;
   logic        if_ready;
   logic        dm_ready;
   logic        is_store;
   logic [31:0] resp_data;

   // Round-robin choice: data wins if it is alone or if fetch won last time.
   // Ready is also held low while reset is asserted so nothing leaks out.
   always_comb begin
      pick_dm  = bus.i_dm_req && (!bus.i_if_req || (last_grant_q == GNT_IF));
      if_ready = i_rst_n && (state_q == ST_IDLE) && bus.i_if_req && !pick_dm;
      dm_ready = i_rst_n && (state_q == ST_IDLE) && pick_dm;
      is_store = (grant_q == GNT_DM) && wen_q;
      resp_data = is_store ? 32'h0 : bus.i_mem_rdata;
   end

   // Next-state logic: accept in IDLE, hold the request in ISSUE until the
   // memory takes it, collect completion in ISSUE or WAIT, pulse in RESP.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      rdata_d      = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (dm_ready) begin
               grant_d      = GNT_DM;
               last_grant_d = GNT_DM;
               addr_d       = bus.i_dm_addr & 32'hFFFF_FFFC;
               wen_d        = bus.i_dm_wen;
               wdata_d      = bus.i_dm_wdata;
               mask_d       = bus.i_dm_mask;
               state_d      = ST_ISSUE;
            end else if (if_ready) begin
               grant_d      = GNT_IF;
               last_grant_d = GNT_IF;
               addr_d       = bus.i_if_addr & 32'hFFFF_FFFC;
               wen_d        = 1'b0;
               wdata_d      = 32'h0;
               mask_d       = 4'b1111;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.i_mem_ready) begin
               if (bus.i_mem_rvalid) begin
                  rdata_d = resp_data;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus.i_mem_rvalid) begin
               rdata_d = resp_data;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset drops any in-flight work.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_IF;
         last_grant_q <= GNT_DM;
         addr_q       <= 32'h0;
         wen_q        <= 1'b0;
         wdata_q      <= 32'h0;
         mask_q       <= 4'h0;
         rdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         rdata_q      <= rdata_d;
      end
   end

   // Drive the port: memory fields straight from the latched request,
   // response data only visible during the owner's rvalid pulse.
   always_comb begin
      bus.o_if_ready  = if_ready;
      bus.o_dm_ready  = dm_ready;
      bus.o_mem_req   = (state_q == ST_ISSUE);
      bus.o_mem_addr  = addr_q;
      bus.o_mem_wen   = wen_q;
      bus.o_mem_wdata = wdata_q;
      bus.o_mem_mask  = mask_q;
      bus.o_if_rvalid = (state_q == ST_RESP) && (grant_q == GNT_IF);
      bus.o_dm_rvalid = (state_q == ST_RESP) && (grant_q == GNT_DM);
      bus.o_if_rdata  = bus.o_if_rvalid ? rdata_q : 32'h0;
      bus.o_dm_rdata  = bus.o_dm_rvalid ? rdata_q : 32'h0;
      bus.o_busy      = (state_q != ST_IDLE);
   end

endmodule
